// File: rtl/urv_divide_iter.sv
// Iterative restoring divider for the uRV execute stage (DIV/DIVU/REM/REMU).
// Resolves g_bits_per_cycle quotient bits per cycle and stalls X until the result is registered.
module urv_divide_iter #(
  parameter int unsigned g_width          = 32,
  parameter int unsigned g_bits_per_cycle = 1,
  parameter int unsigned g_early_out      = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               x_stall_i,
  input  logic               x_kill_i,
  output logic               x_stall_req_o,
  input  logic               d_valid_i,
  input  logic               d_is_divide_i,
  input  logic [2:0]         d_fun_i,
  input  logic [g_width-1:0] d_rs1_i,
  input  logic [g_width-1:0] d_rs2_i,
  output logic [g_width-1:0] x_rd_o
);

  localparam int unsigned NIter = g_width / g_bits_per_cycle;
  localparam int unsigned CntW  = (NIter > 1) ? $clog2(NIter) : 1;
  localparam logic [g_width-1:0] MinVal = {1'b1, {(g_width-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [g_width-1:0]  rem_q, rem_d;
  logic [g_width-1:0]  quo_q, quo_d;
  logic [g_width-1:0]  den_q, den_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                is_rem_q, is_rem_d;
  logic [g_width-1:0]  x_rd_d;

  logic                start, is_signed, rs1_neg, rs2_neg, div_zero, overflow, special;
  logic [g_width-1:0]  rs1_abs, rs2_abs, quo_fix, rem_fix;
  logic                unused_fun;

  assign unused_fun = d_fun_i[2];

  assign start     = d_valid_i & d_is_divide_i & ~x_kill_i;
  assign is_signed = ~d_fun_i[0];
  assign rs1_neg   = is_signed & d_rs1_i[g_width-1];
  assign rs2_neg   = is_signed & d_rs2_i[g_width-1];
  assign rs1_abs   = rs1_neg ? -d_rs1_i : d_rs1_i;
  assign rs2_abs   = rs2_neg ? -d_rs2_i : d_rs2_i;
  assign div_zero  = (d_rs2_i == '0);
  assign overflow  = is_signed & (d_rs1_i == MinVal) & (d_rs2_i == '1);
  assign special   = div_zero | overflow;

  // Chained restoring steps; the remainder stays below the divisor so g_width bits suffice.
  logic [g_width-1:0] step_rem [0:g_bits_per_cycle];
  logic [g_width-1:0] step_quo [0:g_bits_per_cycle];
  logic [g_width:0]   step_sh  [0:g_bits_per_cycle-1];
  logic [g_width:0]   step_df  [0:g_bits_per_cycle-1];

  always_comb begin
    step_rem[0] = rem_q;
    step_quo[0] = quo_q;
    for (int i = 0; i < int'(g_bits_per_cycle); i++) begin
      step_sh[i]    = {step_rem[i], step_quo[i][g_width-1]};
      step_df[i]    = step_sh[i] - {1'b0, den_q};
      step_rem[i+1] = step_df[i][g_width] ? step_sh[i][g_width-1:0] : step_df[i][g_width-1:0];
      step_quo[i+1] = {step_quo[i][g_width-2:0], ~step_df[i][g_width]};
    end
  end

  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (x_kill_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (start) state_d = ((g_early_out != 0) && special) ? StFix : StIter;
        StIter: if (cnt_q == '0) state_d = StFix;
        StFix:  state_d = StDone;
        StDone: if (!x_stall_i) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    x_stall_req_o = ~x_kill_i & (((state_q == StIdle) & start) |
                                 (state_q == StIter) | (state_q == StFix));
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    den_d     = den_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    x_rd_d    = x_rd_o;
    if (state_q == StIdle && start) begin
      cnt_d     = CntW'(NIter - 1);
      den_d     = rs2_abs;
      // Divide-by-zero keeps an all-ones quotient regardless of the dividend sign.
      neg_quo_d = (rs1_neg ^ rs2_neg) & ~div_zero;
      neg_rem_d = rs1_neg;
      is_rem_d  = d_fun_i[1];
      if ((g_early_out != 0) && special) begin
        quo_d = div_zero ? '1 : MinVal;
        rem_d = div_zero ? rs1_abs : '0;
      end else begin
        quo_d = rs1_abs;
        rem_d = '0;
      end
    end else if (state_q == StIter) begin
      rem_d = step_rem[g_bits_per_cycle];
      quo_d = step_quo[g_bits_per_cycle];
      if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
    end else if (state_q == StFix && !x_kill_i) begin
      x_rd_d = is_rem_q ? rem_fix : quo_fix;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      den_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      x_rd_o    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      den_q     <= den_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      x_rd_o    <= x_rd_d;
    end
  end

endmodule

// File: tb/tb_urv_divide_iter.sv
// Bench for urv_divide_iter: four configurations share one stimulus stream and are
// checked every cycle against a cycle-count model plus literal expected results.
module tb_urv_divide_iter;

  localparam int Nit [4] = '{32, 32, 16, 8};
  localparam int Eo  [4] = '{1, 0, 1, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_stall = 1'b0;
  logic        x_kill = 1'b0;
  logic        d_valid = 1'b0;
  logic        d_is_div = 1'b0;
  logic [2:0]  d_fun = 3'b100;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [3:0]  stall_v;
  logic [31:0] rd_v [4];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  urv_divide_iter #(.g_width(32), .g_bits_per_cycle(1), .g_early_out(1)) u_b1 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
    .x_stall_req_o(stall_v[0]), .d_valid_i(d_valid), .d_is_divide_i(d_is_div),
    .d_fun_i(d_fun), .d_rs1_i(rs1), .d_rs2_i(rs2), .x_rd_o(rd_v[0]));
  urv_divide_iter #(.g_width(32), .g_bits_per_cycle(1), .g_early_out(0)) u_b1n (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
    .x_stall_req_o(stall_v[1]), .d_valid_i(d_valid), .d_is_divide_i(d_is_div),
    .d_fun_i(d_fun), .d_rs1_i(rs1), .d_rs2_i(rs2), .x_rd_o(rd_v[1]));
  urv_divide_iter #(.g_width(32), .g_bits_per_cycle(2), .g_early_out(1)) u_b2 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
    .x_stall_req_o(stall_v[2]), .d_valid_i(d_valid), .d_is_divide_i(d_is_div),
    .d_fun_i(d_fun), .d_rs1_i(rs1), .d_rs2_i(rs2), .x_rd_o(rd_v[2]));
  urv_divide_iter #(.g_width(32), .g_bits_per_cycle(4), .g_early_out(1)) u_b4 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
    .x_stall_req_o(stall_v[3]), .d_valid_i(d_valid), .d_is_divide_i(d_is_div),
    .d_fun_i(d_fun), .d_rs1_i(rs1), .d_rs2_i(rs2), .x_rd_o(rd_v[3]));

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // RISC-V M-extension result from plain arithmetic.
  function automatic logic [31:0] ref_div(logic [2:0] fun, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    case (fun)
      3'b100:  return (b == 0) ? 32'hffff_ffff : ovf ? a : 32'(sa / sb);
      3'b101:  return (b == 0) ? 32'hffff_ffff : a / b;
      3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Model: 0 idle, 1 busy, 2 done; result lands when the cycle index reaches the latency.
  int          m_st  [4] = '{default: 0};
  int          m_cyc [4] = '{default: 0};
  int          m_lat [4] = '{default: 0};
  logic [31:0] m_res [4] = '{default: '0};
  logic [31:0] m_rd  [4] = '{default: '0};
  logic        m_start, m_exp_stall, m_special;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_st[k] = 0;
        m_rd[k] = '0;
        check($sformatf("rst_stall[%0d]", k), {31'b0, stall_v[k]}, 32'h0);
        check($sformatf("rst_rd[%0d]", k), rd_v[k], 32'h0);
      end else begin
        m_start     = d_valid && d_is_div && !x_kill;
        m_exp_stall = !x_kill && ((m_st[k] == 0 && m_start) || m_st[k] == 1);
        check($sformatf("stall[%0d]", k), {31'b0, stall_v[k]}, {31'b0, m_exp_stall});
        check($sformatf("rd[%0d]", k), rd_v[k], m_rd[k]);
        if (x_kill) begin
          m_st[k] = 0;
        end else if (m_st[k] == 0) begin
          if (m_start) begin
            m_special = (rs2 == 0) ||
                        (!d_fun[0] && rs1 == 32'h8000_0000 && rs2 == 32'hffff_ffff);
            m_lat[k] = (Eo[k] != 0 && m_special) ? 2 : Nit[k] + 2;
            m_res[k] = ref_div(d_fun, rs1, rs2);
            m_cyc[k] = 1;
            m_st[k]  = 1;
          end
        end else if (m_st[k] == 1) begin
          if (m_cyc[k] == m_lat[k] - 1) begin
            m_rd[k] = m_res[k];
            m_st[k] = 2;
          end else begin
            m_cyc[k]++;
          end
        end else if (!x_stall) begin
          m_st[k] = 0;
        end
      end
    end
  end

  // Start one divide, hold X stalled for 40 cycles, then release it.
  task automatic run_div(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat_b1);
    int hi;
    hi = 0;
    @(posedge clk); #1;
    d_valid = 1'b1; d_is_div = 1'b1; d_fun = fun; rs1 = a; rs2 = b; x_stall = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        d_valid = 1'b0;
      end
      @(negedge clk);
      if (stall_v[0]) hi++;
    end
    check($sformatf("latency %h/%h", a, b), 32'(hi), 32'(lat_b1));
    for (int k = 0; k < 4; k++)
      check($sformatf("result[%0d] fun%b %h/%h", k, fun, a, b), rd_v[k], exp);
    @(posedge clk); #1;
    x_stall = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    d_valid = 1'b1; d_is_div = 1'b0;
    @(negedge clk);
    check("no start without divide", {31'b0, stall_v[0]}, 32'h0);
    @(posedge clk); #1;
    d_valid = 1'b0;

    run_div(3'b101, 32'd100, 32'd7, 32'd14, 34);

    // Kill mid-iteration: stall drops at once, result register untouched.
    @(posedge clk); #1;
    d_valid = 1'b1; d_is_div = 1'b1; d_fun = 3'b101; rs1 = 32'd1000; rs2 = 32'd3;
    x_stall = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        d_valid = 1'b0;
        x_kill  = (c == 10);
      end
      @(negedge clk);
      if (c == 10) begin
        check("kill stall", {31'b0, stall_v[0]}, 32'h0);
        check("kill rd", rd_v[0], 32'd14);
      end
      if (c == 11) check("idle after kill", {31'b0, stall_v[0]}, 32'h0);
    end
    @(posedge clk); #1;
    x_stall = 1'b0;
    @(posedge clk); #1;

    run_div(3'b101, 32'd81, 32'd9, 32'd9, 34);
    run_div(3'b111, 32'd100, 32'd7, 32'd2, 34);
    run_div(3'b100, 32'hffff_fff9, 32'd2, 32'hffff_fffd, 34);
    run_div(3'b110, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 34);
    run_div(3'b100, 32'd7, 32'hffff_fffe, 32'hffff_fffd, 34);
    run_div(3'b100, 32'd5, 32'd0, 32'hffff_ffff, 2);
    run_div(3'b110, 32'd5, 32'd0, 32'd5, 2);
    run_div(3'b100, 32'hffff_fffb, 32'd0, 32'hffff_ffff, 2);
    run_div(3'b100, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 2);
    run_div(3'b110, 32'h8000_0000, 32'hffff_ffff, 32'h0, 2);
    run_div(3'b111, 32'hdead_beef, 32'd0, 32'hdead_beef, 2);

    // Asynchronous reset mid-divide clears outputs without waiting for a clock edge.
    @(posedge clk); #1;
    d_valid = 1'b1; d_is_div = 1'b1; d_fun = 3'b100; rs1 = 32'hffff_ff9c; rs2 = 32'd7;
    x_stall = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      d_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("async rst rd[%0d]", k), rd_v[k], 32'h0);
      check($sformatf("async rst stall[%0d]", k), {31'b0, stall_v[k]}, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    x_stall = 1'b0;
    run_div(3'b100, 32'hffff_ff9c, 32'd7, 32'hffff_fff2, 34);

    for (int i = 0; i < 10; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = {1'b1, 2'($urandom_range(0, 3))};
      a = $urandom;
      if (a == 32'h8000_0000) a = 32'd1;
      if (i % 2 == 0) begin
        b = 32'($urandom_range(1, 50));
        if ($urandom_range(0, 1) == 1) b = -b;
      end else begin
        b = $urandom >> $urandom_range(0, 31);
      end
      if (b == 0) b = 32'd3;
      run_div(f, a, b, ref_div(f, a, b), 34);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
